// File: rtl/tile_line_sched.sv
// Per-scanline scheduler for the background tile fetch engine: launches one fetch
// per visible line, streams the returned tile rows into a ping-pong line buffer.
module tile_line_sched #(
  parameter int COLS        = 40,
  parameter int LAST_VIS    = 479,
  parameter int VTOTAL_LAST = 524
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         line_req,
  input  logic [9:0]   line_vcount,
  input  logic         cfg_we,
  input  logic [1:0]   cfg_tilemap_idx,
  input  logic         overrun_clr,
  input  logic         tile_done,
  input  logic [255:0] tile_data,
  output logic         tile_start,
  output logic [9:0]   tile_vcount,
  output logic [1:0]   tile_tilemap_idx,
  output logic         lb_we,
  output logic         lb_bank,
  output logic [5:0]   lb_addr,
  output logic [255:0] lb_data,
  output logic         busy,
  output logic         overrun
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    FILL   = 3'd2,
    STREAM = 3'd3,
    DRAIN  = 3'd4
  } state_t;

  localparam logic [9:0] LAST_VIS_V    = 10'(LAST_VIS);
  localparam logic [9:0] VTOTAL_LAST_V = 10'(VTOTAL_LAST);
  localparam logic [5:0] LAST_COL      = 6'(COLS - 1);

  state_t       r_state;
  logic         r_fill_cnt;
  logic [5:0]   r_col;
  logic         r_tile_start;
  logic [9:0]   r_tile_vcount;
  logic [1:0]   r_pending;
  logic [1:0]   r_active;
  logic         r_lb_we;
  logic         r_lb_bank;
  logic         r_busy;
  logic         r_overrun;

  logic         w_visible;
  logic         w_frame_end;
  logic         w_accept;
  logic         w_target_lsb;

  assign w_visible   = (line_vcount < LAST_VIS_V);
  assign w_frame_end = (line_vcount == VTOTAL_LAST_V);
  assign w_accept    = line_req && (w_visible || w_frame_end);
  // Only the bank bit of the target line (vcount+1, or 0 at frame wrap) is needed.
  assign w_target_lsb = w_frame_end ? 1'b0 : ~line_vcount[0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_fill_cnt    <= 1'b0;
      r_col         <= 6'd0;
      r_tile_start  <= 1'b0;
      r_tile_vcount <= 10'd0;
      r_pending     <= 2'd0;
      r_active      <= 2'd0;
      r_lb_we       <= 1'b0;
      r_lb_bank     <= 1'b0;
      r_busy        <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      if (cfg_we) begin
        r_pending <= cfg_tilemap_idx;
      end

      // A dropped request outranks a clear in the same cycle.
      if (line_req && (r_state != IDLE)) begin
        r_overrun <= 1'b1;
      end else if (overrun_clr) begin
        r_overrun <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state       <= LAUNCH;
            r_tile_start  <= 1'b1;
            r_busy        <= 1'b1;
            r_lb_bank     <= w_target_lsb;
            r_tile_vcount <= line_vcount;
            if (w_frame_end) begin
              r_active <= r_pending;
            end
          end
        end
        LAUNCH: begin
          r_tile_start <= 1'b0;
          r_fill_cnt   <= 1'b0;
          r_state      <= FILL;
        end
        FILL: begin
          // Two cycles of engine latency before column 0 is on tile_data.
          if (r_fill_cnt) begin
            r_state <= STREAM;
            r_lb_we <= 1'b1;
            r_col   <= 6'd0;
          end else begin
            r_fill_cnt <= 1'b1;
          end
        end
        STREAM: begin
          if (r_col == LAST_COL) begin
            r_lb_we <= 1'b0;
            r_col   <= 6'd0;
            if (tile_done) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state <= DRAIN;
            end
          end else begin
            r_col <= r_col + 6'd1;
          end
        end
        DRAIN: begin
          if (tile_done) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state      <= IDLE;
          r_tile_start <= 1'b0;
          r_lb_we      <= 1'b0;
          r_col        <= 6'd0;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

  assign tile_start       = r_tile_start;
  assign tile_vcount      = r_tile_vcount;
  assign tile_tilemap_idx = r_active;
  assign lb_we            = r_lb_we;
  assign lb_bank          = r_lb_bank;
  assign lb_addr          = r_col;
  assign lb_data          = tile_data;
  assign busy             = r_busy;
  assign overrun          = r_overrun;

endmodule

// File: doc/tile_line_sched.md
# tile_line_sched

Per-scanline scheduler for the background tile fetch engine. On each line request from the VGA timing logic it decides whether a fetch is needed. It launches the engine for the next visible line and streams the 40 returned 256-bit tile rows into a ping-pong line buffer. It also applies CPU tilemap selection tear-free at frame boundaries.

## Interface
Parameters:
- COLS, 40, tile columns per line
- LAST_VIS, 479, last visible vcount
- VTOTAL_LAST, 524, last vcount of frame

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- line_req  in  1  one-cycle pulse at start of horizontal blank
- line_vcount  in  10  current vcount, valid with line_req
- cfg_we  in  1  CPU write strobe for tilemap select
- cfg_tilemap_idx  in  2  requested tilemap
- overrun_clr  in  1  clears overrun flag
- tile_done  in  1  engine idle flag
- tile_data  in  256  engine tile row output
- tile_start  out  1  one-cycle engine launch
- tile_vcount  out  10  vcount presented to engine (held while busy)
- tile_tilemap_idx  out  2  active tilemap to engine
- lb_we  out  1  line buffer write enable
- lb_bank  out  1  target bank = bit 0 of target line
- lb_addr  out  6  column being written
- lb_data  out  256  = tile_data, passed combinationally
- busy  out  1  high from launch to return to IDLE
- overrun  out  1  sticky: line_req dropped while busy

## Operation
- States: IDLE, LAUNCH, FILL, STREAM, DRAIN.
- IDLE, line_req with line_vcount < LAST_VIS:
  - target = line_vcount+1.
  - Latch tile_vcount = line_vcount.
  - Go to LAUNCH.
- IDLE, line_req with line_vcount == VTOTAL_LAST:
  - target = 0.
  - Copy pending tilemap into active.
  - Go to LAUNCH.
- IDLE, line_req with vcount LAST_VIS..VTOTAL_LAST-1: ignored; no launch, no flag.
- LAUNCH (1 cycle): tile_start=1, busy=1, lb_bank = target[0]. Go to FILL.
- FILL (2 cycles): engine pipeline latency; no writes.
- STREAM (COLS cycles):
  - lb_we=1; lb_addr counts 0..39 from an internal counter.
  - Last write goes to DRAIN.
- DRAIN: wait until tile_done==1, then go to IDLE with busy=0.
- line_req while not IDLE:
  - The request is dropped and overrun is set.
  - Set wins over a simultaneous overrun_clr.
- cfg_we writes the pending register at any time.
  - A write in the same cycle as a frame latch is not used by that latch; it applies next frame.
- Outputs not listed in the current state are 0.
- lb_bank and tile_vcount hold their last values.
- Arithmetic:
  - Target computed in 10 bits.
  - lb_addr is 6-bit and never exceeds 39.

## Timing
- Reset (asynchronous, reset=0):
  - State IDLE; all outputs 0.
  - Pending and active tilemap = 0, overrun = 0.
  - Takes effect mid-stream immediately; no further writes issue.
- line_req sampled at cycle R:
  - tile_start at R+1.
  - lb_we for column k at R+4+k, k=0..39 (last at R+43).
  - If tile_done is already 1, IDLE at R+44 and busy falls there.
  - Earliest accepted next line_req is R+44.
- lb_data for column k equals tile_data in the same cycle lb_we/lb_addr=k is asserted.
- Engine contract: tile_data for column k is valid exactly 3 cycles after tile_start plus k.

## Test plan
- Reset, then line_req with vcount=10 at cycle R:
  - tile_start at R+1 with tile_vcount=10.
  - 40 writes R+4..R+43, lb_addr 0..39, lb_bank=1.
  - busy low at R+44.
- line_req with vcount=500 -> no tile_start, no lb_we, overrun stays 0.
- Frame latch:
  - Sequence: cfg_we idx=2 mid-frame, then line_req vcount=524.
  - Required: tile_tilemap_idx=2 at launch; lb_bank=0; write at the same cycle as the latch leaves active unchanged.
- line_req at R+20 during streaming:
  - overrun=1 and the line completes untouched.
  - overrun_clr with a simultaneous drop keeps overrun=1; overrun_clr alone clears it.
- tile_done held 0 after STREAM for 5 cycles -> stays in DRAIN with busy=1; IDLE one cycle after tile_done rises.
- reset asserted at lb_addr=17 -> lb_we, busy, tile_start immediately 0; a fresh line_req after release runs a full 40-column line.
